// File: rtl/exec_step_controller.sv
// Run/step/halt sequencer: debounces three buttons and issues the one-cycle CpuEn advance enable.
// Define BREAKPOINT_EN to enable the PC breakpoint (BRK state, BreakAddr comparator, break mask).
module exec_step_controller #(
  parameter int unsigned DEB_CYCLES = 250000,
  parameter int unsigned RUN_DIV    = 50000000,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             BtnRun,
  input  logic             BtnStep,
  input  logic             BtnHalt,
  input  logic [31:0]      PCValue,
  input  logic [31:0]      BreakAddr,
  output logic             CpuEn,
  output logic [1:0]       State,
  output logic             Running,
  output logic             BreakHit,
  output logic [CNT_W-1:0] InstrCount
);

  localparam int unsigned DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned DIV_W  = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam int unsigned NBTN   = 3;
  localparam int unsigned B_RUN  = 0;
  localparam int unsigned B_STEP = 1;
  localparam int unsigned B_HALT = 2;

  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_STEP = 2'b01,
    ST_RUN  = 2'b10,
    ST_BRK  = 2'b11
  } state_e;

  logic [NBTN-1:0] btn_raw;
  logic [NBTN-1:0] pulse;
  logic            p_run;
  logic            p_step;
  logic            p_halt;

  assign btn_raw = {BtnHalt, BtnStep, BtnRun};

  // Per button: 2-FF synchroniser, consecutive-sample debounce, rising-edge pulse.
  for (genvar g = 0; g < NBTN; g++) begin : g_btn
    logic             s1_q;
    logic             s2_q;
    logic             deb_q;
    logic             deb_d;
    logic             prev_q;
    logic [DEB_W-1:0] cnt_q;
    logic [DEB_W-1:0] cnt_d;

    always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
        s1_q   <= 1'b0;
        s2_q   <= 1'b0;
        deb_q  <= 1'b0;
        prev_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        s1_q   <= btn_raw[g];
        s2_q   <= s1_q;
        deb_q  <= deb_d;
        prev_q <= deb_q;
        cnt_q  <= cnt_d;
      end
    end

    // Counter runs only while the synchronised level disagrees with the accepted one.
    always_comb begin
      deb_d = deb_q;
      cnt_d = '0;
      if (s2_q != deb_q) begin
        if (cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
          deb_d = s2_q;
        end else begin
          cnt_d = cnt_q + DEB_W'(1);
        end
      end
    end

    assign pulse[g] = deb_q & ~prev_q;
  end

  assign p_run  = pulse[B_RUN];
  assign p_step = pulse[B_STEP];
  assign p_halt = pulse[B_HALT];

  state_e             state_q;
  state_e             state_d;
  logic [DIV_W-1:0]   div_q;
  logic [DIV_W-1:0]   div_d;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;
  logic               running_q;
  logic               brk_q;
  logic               tick;
  logic               trap;

  assign tick = (state_q == ST_RUN) && (div_q == DIV_W'(RUN_DIV - 1));

`ifdef BREAKPOINT_EN
  logic mask_q;
  logic mask_d;

  assign trap = tick && (PCValue == BreakAddr) && !mask_q;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      mask_q <= 1'b0;
    end else begin
      mask_q <= mask_d;
    end
  end

  // Resuming from BRK lets the trapped instruction run once before re-arming.
  always_comb begin
    mask_d = mask_q;
    if (CpuEn) begin
      mask_d = 1'b0;
    end else if ((state_q == ST_BRK) && !p_halt && (p_step || p_run)) begin
      mask_d = 1'b1;
    end
  end
`else
  logic unused_bp;

  assign trap      = 1'b0;
  assign unused_bp = ^{PCValue, BreakAddr};
`endif

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= ST_HALT;
      div_q     <= '0;
      count_q   <= '0;
      running_q <= 1'b0;
      brk_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      count_q   <= count_d;
      running_q <= (state_d == ST_RUN);
      brk_q     <= (state_d == ST_BRK);
    end
  end

  // Next state, divider and CpuEn; halt outranks step outranks run.
  always_comb begin
    state_d = state_q;
    div_d   = '0;
    count_d = count_q;
    CpuEn   = 1'b0;
    case (state_q)
      ST_HALT: begin
        if (!p_halt) begin
          if (p_step) begin
            state_d = ST_STEP;
          end else if (p_run) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_STEP: begin
        CpuEn   = 1'b1;
        state_d = ST_HALT;
      end
      ST_RUN: begin
        if (p_halt) begin
          state_d = ST_HALT;
        end else if (trap) begin
          state_d = ST_BRK;
        end else begin
          CpuEn = tick;
          div_d = tick ? '0 : div_q + DIV_W'(1);
        end
      end
      ST_BRK: begin
        if (p_halt) begin
          state_d = ST_HALT;
        end else if (p_step) begin
          state_d = ST_STEP;
        end else if (p_run) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
    if (CpuEn) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  assign State      = state_q;
  assign Running    = running_q;
  assign BreakHit   = brk_q;
  assign InstrCount = count_q;

endmodule
